// File: rtl/na_conf_wb_regfile_if.sv
// rtl/na_conf_wb_regfile_if.sv - Wishbone B3 bus bundle between the tile bus and the NA conf regfile
interface na_conf_wb_regfile_if;
  logic [31:0] wbs_adr_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_cab_i;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_adr_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
           wbs_cti_i, wbs_bte_i, wbs_cab_i,
    input  wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
  );

  modport slave (
    input  wbs_adr_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
           wbs_cti_i, wbs_bte_i, wbs_cab_i,
    output wbs_ack_o, wbs_err_o, wbs_rty_o, wbs_dat_o
  );
endinterface

// File: rtl/na_conf_wb_regfile.sv
// rtl/na_conf_wb_regfile.sv - NA configuration Wishbone slave with user registers and bursts
// CDC control register at 0x20 is built only when OPTIMSOC_NA_CONF_CDC_EN is defined.
module na_conf_wb_regfile #(
  parameter logic [31:0] TILEID             = 32'd0,
  parameter logic [31:0] NUMTILES           = 32'd1,
  parameter logic [31:0] COREBASE           = 32'd0,
  parameter logic [31:0] DOMAIN_NUMCORES    = 32'd1,
  parameter logic [31:0] GLOBAL_MEMORY_SIZE = 32'h0,
  parameter logic [31:0] GLOBAL_MEMORY_TILE = 32'h0,
  parameter logic [31:0] LOCAL_MEMORY_SIZE  = 32'h0,
  parameter int          NUM_USER_REGS      = 4,
  parameter logic [31:0] USER_RESET         = 32'h0,
  parameter int          ADDR_WIDTH         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  na_conf_wb_regfile_if.slave        wb
`ifdef OPTIMSOC_NA_CONF_CDC_EN
  ,
  output logic [2:0]                 cdc_conf,
  output logic                       cdc_enable
`endif
);

  localparam int WA = ADDR_WIDTH - 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_BURST  = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;

`ifdef OPTIMSOC_NA_CONF_CDC_EN
  localparam logic CDC_PRESENT = 1'b1;
`else
  localparam logic CDC_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS = {16'h0, 8'(NUM_USER_REGS), 5'b0, CDC_PRESENT, 2'b00};

  logic [1:0]    state_q, state_d;
  logic [WA-1:0] addr_q, addr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   user_q [NUM_USER_REGS];

  logic          req;
  logic          beat_go;
  logic [WA-1:0] beat_addr;
  logic [WA-1:0] wrap_mask;
  logic [WA-1:0] burst_next;
  logic [3:0]    uidx;
  logic          hit;
  logic          writable;
  logic          user_hit;
  logic          beat_err;
  logic          wr_en;
  logic [31:0]   rd_data;
  logic          unused_bits;

  assign req         = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign unused_bits = ^{wb.wbs_cab_i, wb.wbs_adr_i[31:ADDR_WIDTH], wb.wbs_adr_i[1:0]};

  // Wrap bursts only let the low log2(N) word bits count; linear lets all bits count.
  always_comb begin
    case (wb.wbs_bte_i)
      2'b01:   wrap_mask = WA'(3);
      2'b10:   wrap_mask = WA'(7);
      2'b11:   wrap_mask = WA'(15);
      default: wrap_mask = '1;
    endcase
    burst_next = (addr_q & ~wrap_mask) | ((addr_q + WA'(1)) & wrap_mask);
  end

  always_comb begin
    beat_go   = 1'b0;
    beat_addr = addr_q;
    if (state_q == ST_IDLE) begin
      beat_go   = req;
      beat_addr = wb.wbs_adr_i[ADDR_WIDTH-1:2];
    end else if (state_q == ST_BURST) begin
      beat_go   = req;
      beat_addr = burst_next;
    end
  end

`ifdef OPTIMSOC_NA_CONF_CDC_EN
  logic [2:0] cdc_conf_q;
  logic       cdc_en_q;
  logic       cdc_hit;

  assign cdc_hit    = (beat_addr == WA'(8));
  assign cdc_conf   = cdc_conf_q;
  assign cdc_enable = cdc_en_q;
`endif

  assign uidx = beat_addr[3:0];

  always_comb begin
    rd_data  = '0;
    hit      = 1'b0;
    writable = 1'b0;
    user_hit = 1'b0;
    if (beat_addr < WA'(8)) begin
      hit = 1'b1;
      case (beat_addr[2:0])
        3'd0:    rd_data = TILEID;
        3'd1:    rd_data = NUMTILES;
        3'd2:    rd_data = COREBASE;
        3'd3:    rd_data = DOMAIN_NUMCORES;
        3'd4:    rd_data = GLOBAL_MEMORY_SIZE;
        3'd5:    rd_data = GLOBAL_MEMORY_TILE;
        3'd6:    rd_data = LOCAL_MEMORY_SIZE;
        default: rd_data = CAPS;
      endcase
`ifdef OPTIMSOC_NA_CONF_CDC_EN
    end else if (cdc_hit) begin
      hit      = 1'b1;
      writable = 1'b1;
      rd_data  = {23'b0, cdc_en_q, 5'b0, cdc_conf_q};
`endif
    end else if (beat_addr[WA-1:4] == (WA-4)'(1)) begin
      for (int i = 0; i < NUM_USER_REGS; i++) begin
        if (uidx == 4'(i)) begin
          user_hit = 1'b1;
          rd_data  = user_q[i];
        end
      end
      hit      = user_hit;
      writable = user_hit;
    end
  end

  assign beat_err = !hit || (wb.wbs_we_i && !writable);
  assign wr_en    = beat_go && wb.wbs_we_i && !beat_err;

  // A final or failing beat goes through SINGLE so the still-asserted stb during its ack is ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    case (state_q)
      ST_IDLE, ST_BURST: begin
        if (beat_go) begin
          addr_d  = beat_addr;
          ack_d   = !beat_err;
          err_d   = beat_err;
          dat_d   = (!beat_err && !wb.wbs_we_i) ? rd_data : 32'h0;
          state_d = (wb.wbs_cti_i == CTI_INCR && !beat_err) ? ST_BURST : ST_SINGLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_USER_REGS; i++) user_q[i] <= USER_RESET;
    end else if (wr_en && user_hit) begin
      for (int i = 0; i < NUM_USER_REGS; i++) begin
        if (uidx == 4'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wb.wbs_sel_i[b]) user_q[i][8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef OPTIMSOC_NA_CONF_CDC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdc_conf_q <= 3'b0;
      cdc_en_q   <= 1'b0;
    end else if (wr_en && cdc_hit) begin
      if (wb.wbs_sel_i[0]) cdc_conf_q <= wb.wbs_dat_i[2:0];
      if (wb.wbs_sel_i[1]) cdc_en_q   <= wb.wbs_dat_i[8];
    end
  end
`endif

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_err_o = err_q;
  assign wb.wbs_rty_o = 1'b0;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_na_conf_wb_regfile.sv
// tb/tb_na_conf_wb_regfile.sv - directed bench for na_conf_wb_regfile (optionally with OPTIMSOC_NA_CONF_CDC_EN)
module tb_na_conf_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  na_conf_wb_regfile_if bus ();

`ifdef OPTIMSOC_NA_CONF_CDC_EN
  logic [2:0] cdc_conf;
  logic       cdc_enable;
`endif

  na_conf_wb_regfile #(
    .TILEID             (32'd5),
    .NUMTILES           (32'd3),
    .COREBASE           (32'd7),
    .DOMAIN_NUMCORES    (32'd2),
    .GLOBAL_MEMORY_SIZE (32'h4000_0000),
    .GLOBAL_MEMORY_TILE (32'h0010_0000),
    .LOCAL_MEMORY_SIZE  (32'h8000),
    .NUM_USER_REGS      (4),
    .USER_RESET         (32'h0),
    .ADDR_WIDTH         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (bus.slave)
`ifdef OPTIMSOC_NA_CONF_CDC_EN
    ,
    .cdc_conf   (cdc_conf),
    .cdc_enable (cdc_enable)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_cti_i = 3'b000;
    bus.wbs_bte_i = 2'b00;
    bus.wbs_cab_i = 1'b0;
  endtask

  // Classic cycle with stb held through the ack cycle; the following cycle must be idle.
  task automatic wb_single(input string tag, input logic [31:0] adr, input logic we,
                           input logic [31:0] wd, input logic [3:0] sel,
                           input logic exp_err, input logic [31:0] exp_dat);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = wd;
    bus.wbs_sel_i = sel;
    bus.wbs_cti_i = 3'b000;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    check({tag, " ack"}, 32'(bus.wbs_ack_o), 32'(!exp_err));
    check({tag, " err"}, 32'(bus.wbs_err_o), 32'(exp_err));
    if (!we) check({tag, " dat"}, bus.wbs_dat_o, exp_dat);
    @(posedge clk); #1;
    check({tag, " gap"}, 32'({bus.wbs_ack_o, bus.wbs_err_o}), 32'h0);
    bus_idle();
  endtask

  task automatic burst_start(input logic [31:0] adr, input logic [1:0] bte);
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_cti_i = 3'b010;
    bus.wbs_bte_i = bte;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
  endtask

  task automatic burst_beat(input string tag, input logic exp_err, input logic [31:0] exp_dat,
                            input logic [2:0] next_cti);
    @(posedge clk); #1;
    check({tag, " ack"}, 32'(bus.wbs_ack_o), 32'(!exp_err));
    check({tag, " err"}, 32'(bus.wbs_err_o), 32'(exp_err));
    if (!exp_err) check({tag, " dat"}, bus.wbs_dat_o, exp_dat);
    bus.wbs_cti_i = next_cti;
  endtask

  task automatic burst_end(input string tag);
    @(posedge clk); #1;
    check({tag, " end"}, 32'({bus.wbs_ack_o, bus.wbs_err_o}), 32'h0);
    bus_idle();
  endtask

  logic [31:0] exp_const [7];
  logic [31:0] ureg [4];

  initial begin
    exp_const[0] = 32'd5;          exp_const[1] = 32'd3;
    exp_const[2] = 32'd7;          exp_const[3] = 32'd2;
    exp_const[4] = 32'h4000_0000;  exp_const[5] = 32'h0010_0000;
    exp_const[6] = 32'h8000;
    ureg[0] = 32'h00BB00DD;        ureg[1] = 32'h11111111;
    ureg[2] = 32'h22222222;        ureg[3] = 32'h33333333;
    bus.wbs_adr_i = 32'h0;
    bus_idle();

    #12;
    check("reset ack", 32'(bus.wbs_ack_o), 32'h0);
    check("reset err", 32'(bus.wbs_err_o), 32'h0);
    check("reset dat", bus.wbs_dat_o, 32'h0);
    check("reset rty", 32'(bus.wbs_rty_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      wb_single($sformatf("const%0d", i), 32'(i * 4), 1'b0, 32'h0, 4'hF, 1'b0, exp_const[i]);
    wb_single("hi bits ignored", 32'h0001_0000, 1'b0, 32'h0, 4'hF, 1'b0, 32'd5);
`ifdef OPTIMSOC_NA_CONF_CDC_EN
    wb_single("caps", 32'h1C, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0000_0404);
`else
    wb_single("caps", 32'h1C, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0000_0400);
`endif

    wb_single("user0 reset", 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
    wb_single("wr user0", 32'h40, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    wb_single("rd user0", 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, 32'h00BB00DD);
    wb_single("wr ro 04", 32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    wb_single("rd 04 after", 32'h04, 1'b0, 32'h0, 4'hF, 1'b0, 32'd3);
    wb_single("wr ro 1C", 32'h1C, 1'b1, 32'h0, 4'hF, 1'b1, 32'h0);
    wb_single("rd unmapped 30", 32'h30, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
    wb_single("rd unmapped 50", 32'h50, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
    wb_single("wr unmapped 50", 32'h50, 1'b1, 32'h1, 4'hF, 1'b1, 32'h0);
    for (int i = 1; i < 4; i++)
      wb_single($sformatf("wr user%0d", i), 32'(32'h40 + i * 4), 1'b1, ureg[i], 4'hF, 1'b0, 32'h0);

    burst_start(32'h40, 2'b00);
    burst_beat("lin b0", 1'b0, ureg[0], 3'b010);
    burst_beat("lin b1", 1'b0, ureg[1], 3'b010);
    burst_beat("lin b2", 1'b0, ureg[2], 3'b111);
    burst_beat("lin b3", 1'b0, ureg[3], 3'b000);
    burst_end("lin");

    burst_start(32'h48, 2'b01);
    burst_beat("wrap4 b0", 1'b0, ureg[2], 3'b010);
    burst_beat("wrap4 b1", 1'b0, ureg[3], 3'b010);
    burst_beat("wrap4 b2", 1'b0, ureg[0], 3'b111);
    burst_beat("wrap4 b3", 1'b0, ureg[1], 3'b000);
    burst_end("wrap4");

    burst_start(32'h4C, 2'b00);
    burst_beat("errb b0", 1'b0, ureg[3], 3'b010);
    burst_beat("errb b1", 1'b1, 32'h0, 3'b010);
    burst_end("errb");

    burst_start(32'h40, 2'b00);
    burst_beat("drop b0", 1'b0, ureg[0], 3'b010);
    bus.wbs_cyc_i = 1'b0;
    burst_end("drop");

    burst_start(32'h40, 2'b00);
    burst_beat("rst b0", 1'b0, ureg[0], 3'b010);
    burst_beat("rst b1", 1'b0, ureg[1], 3'b010);
    #2 rst = 1'b1;
    #1;
    check("rst async ack", 32'(bus.wbs_ack_o), 32'h0);
    bus_idle();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++)
      wb_single($sformatf("user%0d after rst", i), 32'(32'h40 + i * 4), 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);

`ifdef OPTIMSOC_NA_CONF_CDC_EN
    check("cdc_conf reset", 32'(cdc_conf), 32'h0);
    wb_single("wr cdc", 32'h20, 1'b1, 32'h105, 4'hF, 1'b0, 32'h0);
    check("cdc_conf", 32'(cdc_conf), 32'h5);
    check("cdc_enable", 32'(cdc_enable), 32'h1);
    wb_single("rd cdc", 32'h20, 1'b0, 32'h0, 4'hF, 1'b0, 32'h105);
`else
    wb_single("rd 20 unmapped", 32'h20, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
    wb_single("wr 20 unmapped", 32'h20, 1'b1, 32'h105, 4'hF, 1'b1, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/na_conf_wb_regfile.md
Name: na_conf_wb_regfile

Overview:
Wishbone B3 slave for the network-adapter configuration space of one tile. It exposes read-only identity and memory-map constants, a capability word, and NUM_USER_REGS writable user registers with byte-lane writes. It supports classic single cycles and registered-feedback incrementing bursts (linear, wrap4, wrap8, wrap16), and signals unmapped or read-only accesses with err. It sits on the tile bus in place of the fixed-function conf slave.

Parameters:
TILEID, 0, tile identifier returned at 0x00
NUMTILES, 1, tile count returned at 0x04
COREBASE, 0, first core index returned at 0x08
DOMAIN_NUMCORES, 1, cores in domain, returned at 0x0C
GLOBAL_MEMORY_SIZE, 32'h0, returned at 0x10
GLOBAL_MEMORY_TILE, 32'h0, returned at 0x14
LOCAL_MEMORY_SIZE, 32'h0, returned at 0x18
NUM_USER_REGS, 4, writable user registers, legal range 1..16
USER_RESET, 32'h0, reset value of every user register
ADDR_WIDTH, 16, decoded address bits; higher address bits are ignored

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wbs_adr_i  in  32  byte address; only bits [ADDR_WIDTH-1:2] are decoded
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_dat_i  in  32  write data
wbs_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst
wbs_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wbs_cab_i  in  1  ignored
wbs_ack_o  out  1  registered acknowledge
wbs_err_o  out  1  registered error
wbs_rty_o  out  1  constant 0
wbs_dat_o  out  32  registered read data

Behaviour:
- Reset: all outputs are 0, state is IDLE, and user registers load USER_RESET. Reset is asynchronous, so a reset mid-burst clears ack/err immediately.
- Register map (byte offsets):
  - 0x00–0x18: the seven constants listed under Parameters.
  - 0x1C CAPS: bit0 = 0 (mpsimple), bit1 = 0 (dma), bit2 = CDC feature present, [15:8] = NUM_USER_REGS, other bits 0.
  - 0x20: CDC register (optional feature).
  - 0x40 + 4*i: user register i, for i < NUM_USER_REGS.
  - Everything else is unmapped.
- Each beat ends in exactly one of ack or err, never both. err is raised for:
  - an unmapped address (read or write);
  - a write to 0x00–0x1C.
  An errored write has no effect. Errored reads return 0.
- Writes: each byte lane is updated only where wbs_sel_i is set. The register value is visible to a read on the next beat.
- FSM states: IDLE, SINGLE, BURST.
  - IDLE: when cyc & stb are seen, address word W is latched, ack/err and data are produced in the next cycle (1-cycle latency), and the beat is executed. The next state is BURST if cti=010, otherwise SINGLE.
  - SINGLE: ack/err is high for exactly one cycle, then the FSM returns to IDLE. A classic back-to-back transfer therefore takes 2 cycles per beat.
  - BURST: while cyc & stb & cti=010, one beat is executed per cycle with ack/err held high. The internal word address advances using bte:
    - linear: W+1;
    - wrapN: the low log2(N) bits increment modulo N and the upper bits are held.
    wbs_adr_i is ignored after the first beat.
  - A beat with cti=111 is executed and acked as the final beat, and the FSM returns to IDLE.
  - An err in a burst terminates the burst: the FSM goes to IDLE after the err beat.
  - If cyc or stb drops during BURST, ack/err go low in the next cycle with no beat executed, and the FSM goes to IDLE.
- Linear bursts wrap at the 2^ADDR_WIDTH boundary.
- Unknown cti values are treated as classic.

Optional Feature:
Macro OPTIMSOC_NA_CONF_CDC_EN.
- Defined:
  - Ports cdc_conf (out, 3 bits) and cdc_enable (out, 1 bit) exist, both driven directly from register 0x20 (cdc_conf = bits [2:0], cdc_enable = bit 8).
  - 0x20 is read/write; unused bits read 0. Reset value is 0.
  - CAPS bit2 = 1.
- Undefined:
  - The ports are absent and 0x20 is unmapped (err).
  - CAPS bit2 = 0.

Test Plan:
1. TILEID=5, LOCAL_MEMORY_SIZE=32'h8000. Classic reads of 0x00 and 0x18 → dat 5 and 32'h8000, ack one cycle after stb, then ack low for one cycle.
2. Write 0x40 with data 32'hAABBCCDD and sel=4'b0101, starting from reset value 0, then read 0x40 → 32'h00BB00DD with ack. Write 0x04 → err=1, ack=0, and a subsequent read of 0x04 still returns NUMTILES.
3. Incrementing burst from 0x40, bte=00, four beats (last beat cti=111), NUM_USER_REGS=4 → four consecutive acks returning regs 0..3, then IDLE.
4. Wrap4 burst starting at 0x48 → beat words 0x48, 0x4C, 0x40, 0x44. A burst starting at 0x4C with NUM_USER_REGS=4 and linear bte → ack on beat 1, err on 0x50, burst terminated.
5. Assert rst during beat 2 of a burst → ack drops the same cycle, user registers read USER_RESET after release. Separately, drop cyc mid-burst → ack low the next cycle.
6. With OPTIMSOC_NA_CONF_CDC_EN: write 0x20 with 32'h105 → cdc_conf=3'b101, cdc_enable=1, CAPS bit2=1. Without it: access to 0x20 → err.
